// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: access sizes, FSM states and
// the default size of the unified instruction/data memory.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } mau_size_t;

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST,
        RMW_RD,
        RMW_WR,
        DONE
    } mau_state_t;

    localparam int MAU_MEM_WORDS = 64;

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane handling: extracts and extends a load lane, and
// merges sub-word store data into an existing memory word.
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  mau_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = word[{offset, 3'b000} +: 8];
        half_lane  = offset[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
                store_word = word;
                store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{~is_unsigned & half_lane[15]}}, half_lane};
                store_word = word;
                if (offset[1]) store_word[31:16] = wdata[15:0];
                else           store_word[15:0]  = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Datapath load/store unit: one outstanding access, alignment and range
// checking, sub-word stores done as read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = MAU_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    mau_state_t  state, state_n;
    mau_size_t   size_q;
    logic [31:0] addr_q, wdata_q, rmw_q;
    logic        uns_q, we_q, err_q;
    logic        req_bad, accept, writing, busy;
    logic [31:0] align_word, load_data, store_word;

    assign accept  = req_valid & req_ready;
    assign req_bad = (req_size == 2'd3)
                   | ((req_size == 2'd1) & req_addr[0])
                   | ((req_size == 2'd2) & (|req_addr[1:0]))
                   | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    // Loads extract from live memory; stores merge into the captured word.
    assign align_word = we_q ? rmw_q : mem_rd;

    mau_lane_align u_align (
        .word        (align_word),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rmw_q      <= '0;
            err_q      <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= mau_size_t'(req_size);
                uns_q   <= req_unsigned;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
            end
            if (state == LD)     resp_rdata <= load_data;
            if (state == RMW_RD) rmw_q      <= mem_rd;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)                         state_n = DONE;
                    else if (!req_we)                    state_n = LD;
                    else if (req_size == 2'(SZ_WORD))    state_n = ST;
                    else                                 state_n = RMW_RD;
                end
            end
            LD:      state_n = DONE;
            ST:      state_n = DONE;
            RMW_RD:  state_n = RMW_WR;
            RMW_WR:  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign writing    = (state == ST) | (state == RMW_WR);
    assign busy       = writing | (state == LD) | (state == RMW_RD);
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign resp_err   = (state == DONE) & err_q;
    assign mem_addr   = busy ? {2'b00, addr_q[31:2]} : '0;
    // A reset landing on the write cycle must not commit the write.
    assign mem_we     = rstn & writing;
    assign mem_wd     = writing ? store_word : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected responses and memory
// writes are queued at request acceptance and matched as the DUT emits them.
module tb_mem_access_unit;

    typedef struct packed {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct packed {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] ram [0:63];
    logic [31:0] mdl [0:63];
    logic        poke_en;
    logic [5:0]  poke_a;
    logic [31:0] poke_d;

    rsp_t        rq[$];
    wr_t         wq[$];
    int          cyc;
    int          n_vec;
    int          n_bad;
    logic [31:0] model_rdata;

    mem_access_unit #(.MEM_WORDS(64)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rd = (mem_addr < 32'd64) ? ram[mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (poke_en)
            ram[poke_a] <= poke_d;
        else if (mem_we && mem_addr < 32'd64)
            ram[mem_addr[5:0]] <= mem_wd;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] w,
                                             input logic [31:0] a,
                                             input logic [1:0] sz,
                                             input logic un);
        logic [31:0] s;
        s = w >> {a[1:0], 3'b000};
        case (sz)
            2'd0:    return un ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'd1:    return un ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] w,
                                             input logic [31:0] a,
                                             input logic [1:0] sz,
                                             input logic [31:0] wd);
        logic [31:0] m;
        if (sz == 2'd2) return wd;
        m = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << {a[1:0], 3'b000};
        return (w & ~m) | ((wd << {a[1:0], 3'b000}) & m);
    endfunction

    function automatic logic bad_model(input logic [1:0] sz,
                                       input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
               (sz == 2'd2 && a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    endfunction

    // Response and write monitor.
    always @(negedge clk) begin
        rsp_t r;
        wr_t  w;
        if (resp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                r = rq.pop_front();
                chk("resp_cycle", cyc, r.due);
                chk("resp_err", 32'(resp_err), 32'(r.err));
                chk("resp_rdata", resp_rdata, r.rdata);
            end
        end
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("we_unexpected", 32'(mem_we), 32'd0);
            end else begin
                w = wq.pop_front();
                chk("we_cycle", cyc, w.due);
                chk("we_addr", mem_addr, w.addr);
                chk("we_data", mem_wd, w.data);
            end
        end
    end

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        mdl[a]  = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic un, input logic [31:0] a,
                         input logic [31:0] wd, input bit keep);
        int   n;
        logic e;
        rsp_t r;
        wr_t  w;
        @(negedge clk);
        req_we       = we;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e = bad_model(sz, a);
        r.err = e;
        r.due = cyc + (e ? 1 : ((we && sz != 2'd2) ? 3 : 2));
        if (!e && !we) model_rdata = ld_model(mdl[a[7:2]], a, sz, un);
        r.rdata = model_rdata;
        rq.push_back(r);
        if (!e && we) begin
            mdl[a[7:2]] = st_model(mdl[a[7:2]], a, sz, wd);
            w.due  = cyc + ((sz == 2'd2) ? 1 : 2);
            w.addr = {2'b00, a[31:2]};
            w.data = mdl[a[7:2]];
            wq.push_back(w);
        end
        if (!keep) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", rq.size() + wq.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        model_rdata  = 32'h0;
        rstn         = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        poke_en      = 1'b0;
        poke_a       = 6'd0;
        poke_d       = 32'h0;

        poke(6'd5, 32'h8081_7F12);
        poke(6'd8, 32'h5566_7788);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        rstn = 1'b1;

        // Loads from word 5 = 0x8081_7F12.
        issue(1'b0, 2'd0, 1'b0, 32'h16, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h16, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h14, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);
        drain();

        // Halfword read-modify-write.
        poke(6'd5, 32'h1122_3344);
        issue(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_BEEF, 1'b0);
        drain();
        chk("sh_word5", ram[5], 32'hBEEF_3344);

        // Errors and top-of-memory word store.
        issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'hFC, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 32'h15, 32'hFFFF, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00A5, 1'b0);
        drain();
        chk("sw_word63", ram[63], 32'hDEAD_BEEF);
        chk("sb_word8", ram[8], 32'h5566_A588);

        // Reset while the byte store sits in its write cycle.
        @(negedge clk);
        req_we       = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h22;
        req_wdata    = 32'h0000_0077;
        req_valid    = 1'b1;
        chk("rmw_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("rmw_rst_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        model_rdata = 32'h0;
        @(negedge clk);
        chk("rmw_rst_ready_after", 32'(req_ready), 32'd1);
        chk("rmw_rst_resp", 32'(resp_valid), 32'd0);
        chk("rmw_rst_rdata", resp_rdata, 32'h0);
        chk("rmw_rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        chk("rmw_rst_word8", ram[8], mdl[8]);

        // Back-to-back with req_valid held high.
        issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h1111_1111, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1);
        issue(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_0099, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h46, 32'h0000_8765, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 1'b0);
        drain();
        chk("b2b_word16", ram[16], 32'h1111_9911);
        chk("model_word16", mdl[16], 32'h1111_9911);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
